bcd_to_binary_seq: RTL and testbench

Sequential reverse double-dabble converter that turns a packed multi-digit BCD value into unsigned binary. It accepts one value per start pulse and iterates one shift/adjust step per clock. It signals completion with a one-cycle done pulse. It sits on the input side of display and keypad paths, as the inverse of the team's binary-to-BCD conversion, and feeds the binary arithmetic datapath.

---
 rtl/bcd_to_binary_seq_pkg.sv | 28 ++
 rtl/bcd_to_binary_seq_if.sv | 15 +
 rtl/bcd_to_binary_seq_digit_adjust.sv | 7 +
 rtl/bcd_to_binary_seq.sv | 108 ++++++++++
 tb/tb_bcd_to_binary_seq.sv | 139 +++++++++++++
 5 files changed

// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared types and sizing helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_DIGITS = 3;
    localparam int DEF_BIN_W  = 10;

    // Smallest width w with 2^w > 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        longint lim;
        int     w;
        lim = 64'sd1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 64'sd10;
        end
        w = 0;
        while ((64'sd1 <<< w) < lim) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle between a requester and bcd_to_binary_seq.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      binary_out;
    logic                  invalid;

    modport master (output start, bcd_in, input busy, done, binary_out, invalid);
    modport slave  (input start, bcd_in, output busy, done, binary_out, invalid);
endinterface

// File: rtl/bcd_to_binary_seq_digit_adjust.sv
// One BCD nibble correction step of reverse double-dabble: nibbles >= 8 lose 3.
module bcd_digit_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = nib_i[3] ? (nib_i - 4'd3) : nib_i;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Reverse double-dabble BCD-to-binary converter, one shift/adjust step per clock.
// Optional input digit check enabled by defining BCD2BIN_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | iterating BIN_W shift/adjust steps
// DONE  | one-cycle done pulse, may accept the next value directly
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = min_bin_w(DIGITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_to_binary_seq_if.slave   bus
);
    localparam int WORK_W = 4*DIGITS + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                inv_q, inv_d;
    logic [WORK_W-1:0]   shifted;
    logic [WORK_W-1:0]   adjusted;

    assign shifted = work_q >> 1;
    assign adjusted[BIN_W-1:0] = shifted[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .nib_i (shifted[BIN_W + 4*g +: 4]),
            .nib_o (adjusted[BIN_W + 4*g +: 4])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    logic bad_digit;
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        inv_d   = inv_q;
        case (state_q)
            SHIFT: begin
                work_d = adjusted;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    bin_d   = adjusted[BIN_W-1:0];
                    inv_d   = 1'b0;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE->SHIFT gives back-to-back throughput.
                if (bus.start) begin
                    state_d = SHIFT;
                    work_d  = {bus.bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = CNT_W'(BIN_W);
`ifdef BCD2BIN_CHECK_EN
                    if (bad_digit) begin
                        state_d = DONE;
                        work_d  = '0;
                        cnt_d   = '0;
                        bin_d   = '0;
                        inv_d   = 1'b1;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
    assign bus.binary_out = bin_q;
    assign bus.invalid    = inv_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq with default DIGITS=3, BIN_W=10.
module tb_bcd_to_binary_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic convert(input logic [11:0] b, input int exp_val, input int exp_inv,
                           input int exp_lat, input string tag);
        int n;
        bus.start  = 1'b1;
        bus.bcd_in = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        n = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " result"}, 32'(bus.binary_out), exp_val);
        check({tag, " invalid"}, 32'(bus.invalid), exp_inv);
        @(negedge clk);
    endtask

    initial begin
        int n, dones, dlat, rval, d1, d2, r1, r2, bad;
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset out", 32'(bus.binary_out), 0);
        check("reset invalid", 32'(bus.invalid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(12'h000, 0, 0, 11, "zero");
        convert(12'h999, 999, 0, 11, "999");
        convert(12'h255, 255, 0, 11, "255");

        // start during SHIFT must be ignored
        bus.start = 1'b1; bus.bcd_in = 12'h500;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; dlat = 0; rval = 0;
        for (n = 1; n <= 30; n++) begin
            if (n == 3) begin bus.start = 1'b1; bus.bcd_in = 12'h777; end
            else        begin bus.start = 1'b0; bus.bcd_in = '0; end
            if (n == 1) check("ign busy rise", 32'(bus.busy), 1);
            if (bus.done === 1'b1) begin dones++; dlat = n; rval = int'(bus.binary_out); end
            @(negedge clk);
        end
        check("ign done count", dones, 1);
        check("ign latency", dlat, 11);
        check("ign result", rval, 500);

        // start held high: back-to-back conversions
        bus.start = 1'b1; bus.bcd_in = 12'h042;
        @(negedge clk);
        bus.bcd_in = 12'h100;
        d1 = 0; d2 = 0; r1 = 0; r2 = 0; bad = 0;
        for (n = 1; n <= 30; n++) begin
            if (d2 == 0 && bus.busy === bus.done) bad++;
            if (bus.done === 1'b1) begin
                if (d1 == 0) begin d1 = n; r1 = int'(bus.binary_out); end
                else if (d2 == 0) begin d2 = n; r2 = int'(bus.binary_out); bus.start = 1'b0; end
            end
            @(negedge clk);
        end
        check("b2b first latency", d1, 11);
        check("b2b second latency", d2, 22);
        check("b2b first result", r1, 42);
        check("b2b second result", r2, 100);
        check("b2b busy shape", bad, 0);

        // reset mid-conversion
        bus.start = 1'b1; bus.bcd_in = 12'h999;
        @(negedge clk);
        bus.start = 1'b0; bus.bcd_in = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus.busy), 0);
        check("abort done", 32'(bus.done), 0);
        check("abort out", 32'(bus.binary_out), 0);
        check("abort invalid", 32'(bus.invalid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (n = 0; n < 20; n++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        check("abort no done", dones, 0);
        convert(12'h321, 321, 0, 11, "after abort");

        // exhaustive sweep of legal 3-digit values
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] h, t, u;
            h = 4'(i / 100);
            t = 4'((i / 10) % 10);
            u = 4'(i % 10);
            convert({h, t, u}, i, 0, 11, "sweep");
        end

`ifdef BCD2BIN_CHECK_EN
        convert(12'h1A5, 0, 1, 1, "illegal digit");
        convert(12'h123, 123, 0, 11, "after illegal");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
